// File: rtl/sodor5_tb_pkg.sv
// Shared definitions for the sodor5 verification harness: sequencer state
// encoding, the RV32 idle instruction and register-file geometry.
package sodor5_tb_pkg;

   localparam int          NUM_REGS  = 32;
   localparam int          WORD_SIZE = 32;

   // addi x0,x0,0
   localparam logic [31:0] RV32_NOP  = 32'h0000_0013;

   typedef enum logic [1:0] {
      SEQ_IDLE  = 2'd0,
      SEQ_RUN   = 2'd1,
      SEQ_DRAIN = 2'd2,
      SEQ_DONE  = 2'd3
   } seq_state_e;

   // Increment that sticks at all-ones instead of wrapping.
   function automatic logic [15:0] sat_inc16(input logic [15:0] value);
      if (value == 16'hFFFF) begin
         return value;
      end else begin
         return value + 16'd1;
      end
   endfunction

endpackage

// File: rtl/imem_prog_buf.sv
// Program buffer: DEPTH x 32 register array. Every entry resets to NOP so an
// aborted or never-loaded program only ever feeds harmless instructions.
module imem_prog_buf
   import sodor5_tb_pkg::*;
#(
   parameter int          DEPTH = 16,
   parameter logic [31:0] NOP   = RV32_NOP
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     we,
   input  logic [$clog2(DEPTH)-1:0] waddr,
   input  logic [31:0]              wdata,
   input  logic [$clog2(DEPTH)-1:0] raddr,
   output logic [31:0]              rdata
);

   logic [31:0] mem_r [DEPTH];

   // Storage: async clear to NOP, synchronous single-port write.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_r[i] <= NOP;
         end
      end else if (we) begin
         mem_r[waddr] <= wdata;
      end
   end

   // DEPTH is a power of two, so every raddr value names a real entry.
   assign rdata = mem_r[raddr];

endmodule

// File: rtl/imem_program_sequencer.sv
// Replays the loaded program buffer into the core's instruction response
// port: optional loop passes, then a NOP-only drain, then a done pulse.
// All outputs come straight from flops; responses lag requests by one cycle.
module imem_program_sequencer
   import sodor5_tb_pkg::*;
#(
   parameter int          DEPTH        = 16,
   parameter int          DRAIN_CYCLES = 5,
   parameter logic [31:0] NOP          = RV32_NOP
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     cfg_we,
   input  logic [$clog2(DEPTH)-1:0] cfg_addr,
   input  logic [31:0]              cfg_wdata,
   input  logic [$clog2(DEPTH):0]   cfg_len,
   input  logic [7:0]               cfg_loops,
   input  logic                     start,
   input  logic                     imem_req_valid,
   output logic                     imem_resp_valid,
   output logic [31:0]              imem_resp_bits_data,
   output logic                     busy,
   output logic                     done,
   output logic [$clog2(DEPTH)-1:0] pc_idx,
   output logic [15:0]              issued_count
);

   localparam int              AW         = $clog2(DEPTH);
   localparam int              DW         = $clog2(DRAIN_CYCLES + 1);
   localparam logic [AW:0]     LEN_MAX    = (AW+1)'(DEPTH);
   localparam logic [AW:0]     LEN_ONE    = (AW+1)'(1);
   localparam logic [AW-1:0]   PC_ZERO    = AW'(0);
   localparam logic [AW-1:0]   PC_ONE     = AW'(1);
   localparam logic [DW-1:0]   DRAIN_ZERO = DW'(0);
   localparam logic [DW-1:0]   DRAIN_ONE  = DW'(1);
   localparam logic [DW-1:0]   DRAIN_LAST = DW'(DRAIN_CYCLES - 1);

   seq_state_e    state_r,     state_n_s;
   logic [AW-1:0] pc_idx_r,    pc_idx_n_s;
   logic [AW:0]   len_r,       len_n_s;
   logic [AW:0]   len_clamp_s;
   logic [7:0]    loops_r,     loops_n_s;
   logic [7:0]    loop_cnt_r,  loop_cnt_n_s;
   logic [DW-1:0] drain_cnt_r, drain_cnt_n_s;
   logic [15:0]   issued_r,    issued_n_s;
   logic          valid_r,     valid_n_s;
   logic [31:0]   data_r,      data_n_s;
   logic          done_r,      done_n_s;
   logic          busy_r,      busy_n_s;

   logic          buf_we_s;
   logic [31:0]   buf_rdata_s;
   logic          end_of_pass_s;
   logic          last_loop_s;
   logic          drain_last_s;

   // Configuration writes are only accepted while no run is in flight.
   assign buf_we_s = cfg_we && ((state_r == SEQ_IDLE) || (state_r == SEQ_DONE));

   imem_prog_buf #(
      .DEPTH (DEPTH),
      .NOP   (NOP)
   ) u_buf (
      .clk   (clk),
      .rst_n (reset),
      .we    (buf_we_s),
      .waddr (cfg_addr),
      .wdata (cfg_wdata),
      .raddr (pc_idx_r),
      .rdata (buf_rdata_s)
   );

   // Wrap is an explicit compare against len-1 so short programs never rely
   // on the 4-bit index overflowing.
   assign end_of_pass_s = ({1'b0, pc_idx_r} == (len_r - LEN_ONE));
   assign last_loop_s   = (loop_cnt_r == (loops_r - 8'd1));
   assign drain_last_s  = (drain_cnt_r == DRAIN_LAST);

   // Next-state and next-output logic for the sequencer.
   always_comb begin
      state_n_s     = state_r;
      pc_idx_n_s    = pc_idx_r;
      len_n_s       = len_r;
      loops_n_s     = loops_r;
      loop_cnt_n_s  = loop_cnt_r;
      drain_cnt_n_s = drain_cnt_r;
      issued_n_s    = issued_r;
      valid_n_s     = 1'b0;
      data_n_s      = data_r;
      done_n_s      = 1'b0;

      if (cfg_len > LEN_MAX) begin
         len_clamp_s = LEN_MAX;
      end else begin
         len_clamp_s = cfg_len;
      end

      case (state_r)
         SEQ_IDLE: begin
            data_n_s = NOP;
            if (start) begin
               len_n_s       = len_clamp_s;
               loops_n_s     = (cfg_loops == 8'd0) ? 8'd1 : cfg_loops;
               pc_idx_n_s    = PC_ZERO;
               loop_cnt_n_s  = 8'd0;
               drain_cnt_n_s = DRAIN_ZERO;
               issued_n_s    = 16'd0;
               if (len_clamp_s == (AW+1)'(0)) begin
                  state_n_s = SEQ_DRAIN;
               end else begin
                  state_n_s = SEQ_RUN;
               end
            end else begin
               state_n_s = SEQ_IDLE;
            end
         end

         SEQ_RUN: begin
            if (imem_req_valid) begin
               valid_n_s  = 1'b1;
               data_n_s   = buf_rdata_s;
               issued_n_s = sat_inc16(issued_r);
               if (end_of_pass_s) begin
                  pc_idx_n_s   = PC_ZERO;
                  loop_cnt_n_s = loop_cnt_r + 8'd1;
                  if (last_loop_s) begin
                     state_n_s = SEQ_DRAIN;
                  end else begin
                     state_n_s = SEQ_RUN;
                  end
               end else begin
                  pc_idx_n_s = pc_idx_r + PC_ONE;
               end
            end else begin
               valid_n_s = 1'b0;
            end
         end

         SEQ_DRAIN: begin
            if (imem_req_valid) begin
               valid_n_s     = 1'b1;
               data_n_s      = NOP;
               drain_cnt_n_s = drain_cnt_r + DRAIN_ONE;
               if (drain_last_s) begin
                  state_n_s = SEQ_DONE;
               end else begin
                  state_n_s = SEQ_DRAIN;
               end
            end else begin
               valid_n_s = 1'b0;
            end
         end

         SEQ_DONE: begin
            done_n_s  = 1'b1;
            data_n_s  = NOP;
            state_n_s = SEQ_IDLE;
         end

         default: begin
            data_n_s  = NOP;
            state_n_s = SEQ_IDLE;
         end
      endcase

      busy_n_s = (state_n_s == SEQ_RUN) || (state_n_s == SEQ_DRAIN);
   end

   // State, counters and output register; reset aborts any run silently.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r     <= SEQ_IDLE;
         pc_idx_r    <= PC_ZERO;
         len_r       <= (AW+1)'(0);
         loops_r     <= 8'd1;
         loop_cnt_r  <= 8'd0;
         drain_cnt_r <= DRAIN_ZERO;
         issued_r    <= 16'd0;
         valid_r     <= 1'b0;
         data_r      <= NOP;
         done_r      <= 1'b0;
         busy_r      <= 1'b0;
      end else begin
         state_r     <= state_n_s;
         pc_idx_r    <= pc_idx_n_s;
         len_r       <= len_n_s;
         loops_r     <= loops_n_s;
         loop_cnt_r  <= loop_cnt_n_s;
         drain_cnt_r <= drain_cnt_n_s;
         issued_r    <= issued_n_s;
         valid_r     <= valid_n_s;
         data_r      <= data_n_s;
         done_r      <= done_n_s;
         busy_r      <= busy_n_s;
      end
   end

   assign imem_resp_valid     = valid_r;
   assign imem_resp_bits_data = data_r;
   assign busy                = busy_r;
   assign done                = done_r;
   assign pc_idx              = pc_idx_r;
   assign issued_count        = issued_r;

endmodule
